// File: rtl/unified_mem_port.sv
// Unified instruction/data memory responder: one word-wide RAM shared by fetch and
// load/store, data granted ahead of fetch, with lane steering, load extension and a stall counter.
module unified_mem_port #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [2:0]  dm_funct3,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        dm_err,
  output logic        stall_if,
  output logic [31:0] stall_cnt
);

  typedef enum logic {S_IDLE = 1'b0, S_RESP = 1'b1} resp_state_t;

  logic [31:0] r_mem [DEPTH_WORDS];

  resp_state_t r_if_state;
  resp_state_t r_dm_state;
  logic [31:0] r_if_rdata;
  logic [31:0] r_dm_rdata;
  logic        r_dm_err;
  logic [31:0] r_stall_cnt;

  logic          w_if_gnt;
  logic          w_dm_gnt;
  logic [AW-1:0] w_if_idx;
  logic [AW-1:0] w_dm_idx;
  logic [1:0]    w_lane;
  logic          w_illegal;
  logic          w_misaligned;
  logic          w_err;
  logic          w_wr_en;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [31:0]   w_shifted;
  logic [31:0]   w_ld_data;
  logic          w_unused;

  // Grants depend only on the request bits
  assign w_dm_gnt = dm_req;
  assign w_if_gnt = if_req & ~dm_req;
  assign if_gnt   = w_if_gnt;
  assign dm_gnt   = w_dm_gnt;
  assign stall_if = if_req & dm_req;

  assign w_if_idx = if_addr[AW+1:2];
  assign w_dm_idx = dm_addr[AW+1:2];
  assign w_lane   = dm_addr[1:0];
  assign w_unused = &{1'b0, if_addr[31:AW+2], if_addr[1:0], dm_addr[31:AW+2]};

  // Access legality, store lane steering and load extension
  always_comb begin
    w_illegal    = dm_we ? (dm_funct3 > 3'b010)
                         : ((dm_funct3 == 3'b011) || (dm_funct3[2:1] == 2'b11));
    w_misaligned = ((dm_funct3[1:0] == 2'b01) && w_lane[0]) ||
                   ((dm_funct3[1:0] == 2'b10) && (w_lane != 2'b00));
    w_err        = w_illegal | w_misaligned;
    w_wr_en      = w_dm_gnt & dm_we & ~w_err;

    w_be    = 4'b1111;
    w_wdata = dm_wdata;
    case (dm_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{dm_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{dm_wdata[15:0]}};
      end
      default: ;
    endcase

    w_shifted = r_mem[w_dm_idx] >> {w_lane, 3'b000};
    case (dm_funct3)
      3'b000:  w_ld_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_ld_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b100:  w_ld_data = {24'd0, w_shifted[7:0]};
      3'b101:  w_ld_data = {16'd0, w_shifted[15:0]};
      default: w_ld_data = w_shifted;
    endcase
  end

  // RAM write port; contents are never reset
  always_ff @(posedge clk) begin
    if (w_wr_en && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_dm_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  // Per-port response FSMs, response data registers and stall counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_if_state  <= S_IDLE;
      r_dm_state  <= S_IDLE;
      r_if_rdata  <= 32'd0;
      r_dm_rdata  <= 32'd0;
      r_dm_err    <= 1'b0;
      r_stall_cnt <= 32'd0;
    end else begin
      if (w_if_gnt) begin
        r_if_state <= S_RESP;
        r_if_rdata <= r_mem[w_if_idx];
      end else begin
        r_if_state <= S_IDLE;
      end

      // Valid stores are silent; loads and any faulting access respond
      if (w_dm_gnt && (w_err || !dm_we)) begin
        r_dm_state <= S_RESP;
        r_dm_err   <= w_err;
        r_dm_rdata <= w_err ? 32'd0 : w_ld_data;
      end else begin
        r_dm_state <= S_IDLE;
        r_dm_err   <= 1'b0;
      end

      if (stall_if && (r_stall_cnt != 32'hFFFF_FFFF)) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign if_rvalid = (r_if_state == S_RESP);
  assign if_rdata  = r_if_rdata;
  assign dm_rvalid = (r_dm_state == S_RESP);
  assign dm_rdata  = r_dm_rdata;
  assign dm_err    = r_dm_err;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_unified_mem_port.sv
// Randomized self-checking bench for unified_mem_port against a byte-addressed memory model.
module tb_unified_mem_port;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned MEMB  = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [2:0]  dm_funct3;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        dm_err;
  logic        stall_if;
  logic [31:0] stall_cnt;

  unified_mem_port #(.DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_funct3(dm_funct3), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
    .dm_rdata(dm_rdata), .dm_err(dm_err),
    .stall_if(stall_if), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  mem_m [MEMB];
  logic        exp_if_rvalid, exp_dm_rvalid, exp_dm_err;
  logic [31:0] exp_if_rdata, exp_dm_rdata, exp_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    int base;
    base = int'((a % MEMB) & ~32'd3);
    return {mem_m[base+3], mem_m[base+2], mem_m[base+1], mem_m[base]};
  endfunction

  function automatic int acc_size(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  // One clock: check grant paths, predict the response, then check registered outputs
  task automatic step();
    int sz;
    logic legal;
    logic [31:0] val, mask;
    #1;
    check("if_gnt",   32'(if_gnt),   32'(if_req && !dm_req));
    check("dm_gnt",   32'(dm_gnt),   32'(dm_req));
    check("stall_if", 32'(stall_if), 32'(if_req && dm_req));

    exp_if_rvalid = 1'b0;
    exp_dm_rvalid = 1'b0;
    exp_dm_err    = 1'b0;
    if (if_req && !dm_req) begin
      exp_if_rvalid = 1'b1;
      exp_if_rdata  = word_at(if_addr);
    end
    if (dm_req) begin
      sz    = acc_size(dm_funct3);
      legal = dm_we ? (dm_funct3 <= 3'd2)
                    : (dm_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      if (!legal || (dm_addr % sz) != 0) begin
        exp_dm_rvalid = 1'b1;
        exp_dm_err    = 1'b1;
        exp_dm_rdata  = 32'd0;
      end else if (dm_we) begin
        for (int k = 0; k < sz; k++) mem_m[(dm_addr + k) % MEMB] = dm_wdata[8*k +: 8];
      end else begin
        val = 32'd0;
        for (int k = 0; k < sz; k++) val = val | (32'(mem_m[(dm_addr + k) % MEMB]) << (8*k));
        if (sz < 4 && dm_funct3 < 3'd4) begin
          mask = (32'd1 << (8*sz)) - 32'd1;
          if (val[8*sz-1]) val = val | ~mask;
        end
        exp_dm_rvalid = 1'b1;
        exp_dm_rdata  = val;
      end
    end
    if (if_req && dm_req && exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 32'd1;

    @(posedge clk);
    #1;
    check("if_rvalid", 32'(if_rvalid), 32'(exp_if_rvalid));
    check("if_rdata",  if_rdata,  exp_if_rdata);
    check("dm_rvalid", 32'(dm_rvalid), 32'(exp_dm_rvalid));
    check("dm_rdata",  dm_rdata,  exp_dm_rdata);
    if (exp_dm_rvalid) check("dm_err", 32'(dm_err), 32'(exp_dm_err));
    check("stall_cnt", stall_cnt, exp_stall);
  endtask

  task automatic idle();
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
  endtask

  task automatic do_st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    idle(); dm_req = 1'b1; dm_we = 1'b1; dm_funct3 = f3; dm_addr = a; dm_wdata = d;
    step();
  endtask

  task automatic do_ld(input logic [2:0] f3, input logic [31:0] a);
    idle(); dm_req = 1'b1; dm_we = 1'b0; dm_funct3 = f3; dm_addr = a;
    step();
  endtask

  task automatic do_if(input logic [31:0] a);
    idle(); if_req = 1'b1; if_addr = a;
    step();
  endtask

  task automatic reset_model();
    exp_if_rvalid = 1'b0; exp_dm_rvalid = 1'b0; exp_dm_err = 1'b0;
    exp_if_rdata = 32'd0; exp_dm_rdata = 32'd0; exp_stall = 32'd0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_if_rvalid"}, 32'(if_rvalid), 32'd0);
    check({tag, "_dm_rvalid"}, 32'(dm_rvalid), 32'd0);
    check({tag, "_dm_err"},    32'(dm_err),    32'd0);
    check({tag, "_if_rdata"},  if_rdata,  32'd0);
    check({tag, "_dm_rdata"},  dm_rdata,  32'd0);
    check({tag, "_stall_cnt"}, stall_cnt, 32'd0);
  endtask

  initial begin
    rst = 1'b1; if_addr = 32'd0; dm_funct3 = 3'd2; dm_addr = 32'd0; dm_wdata = 32'd0;
    idle();
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst = 1'b0;

    // Fill the whole RAM so every model byte is known
    for (int w = 0; w < int'(DEPTH); w++) do_st(3'd2, 32'(4*w), $urandom);

    // Fetch only
    do_st(3'd2, 32'h0C, 32'h0050_0093);
    do_if(32'h0C);
    check("fetch_rdata", if_rdata, 32'h0050_0093);

    // Lanes and extension
    do_st(3'd2, 32'h20, 32'h8000_80F0);
    do_ld(3'd0, 32'h20); check("lb_20",  dm_rdata, 32'hFFFF_FFF0);
    do_ld(3'd4, 32'h21); check("lbu_21", dm_rdata, 32'h0000_0080);
    do_ld(3'd1, 32'h22); check("lh_22",  dm_rdata, 32'hFFFF_8000);
    do_st(3'd0, 32'h23, 32'h0000_007A);
    do_ld(3'd2, 32'h20); check("lw_20",  dm_rdata, 32'h7A00_80F0);

    // Error responses
    do_st(3'd2, 32'h22, 32'hDEAD_BEEF);
    check("sw_mis_err", 32'(dm_err), 32'd1);
    do_ld(3'd2, 32'h20); check("sw_mis_unchanged", dm_rdata, 32'h7A00_80F0);
    do_ld(3'd1, 32'h21); check("lh_mis_err", 32'(dm_err), 32'd1);
    do_ld(3'd3, 32'h20); check("ld_f3_011_err", 32'(dm_err), 32'd1);

    // Back-to-back loads and read-after-write
    do_st(3'd2, 32'h0, 32'h1111_0000);
    do_st(3'd2, 32'h4, 32'h2222_0004);
    do_st(3'd2, 32'h8, 32'h3333_0008);
    do_ld(3'd2, 32'h0); check("b2b_0", dm_rdata, 32'h1111_0000);
    do_ld(3'd2, 32'h4); check("b2b_4_v", 32'(dm_rvalid), 32'd1);
    do_ld(3'd2, 32'h8); check("b2b_8", dm_rdata, 32'h3333_0008);
    do_st(3'd2, 32'h10, 32'hCAFE_F00D);
    do_ld(3'd2, 32'h10); check("raw_10", dm_rdata, 32'hCAFE_F00D);
    do_ld(3'd2, 32'h110); check("alias_110", dm_rdata, 32'hCAFE_F00D);

    // Reset mid-load: pending response clears asynchronously
    idle(); dm_req = 1'b1; dm_funct3 = 3'd2; dm_addr = 32'h20;
    @(posedge clk); #1;
    check("pre_rst_rvalid", 32'(dm_rvalid), 32'd1);
    rst = 1'b1; dm_req = 1'b0;
    #1;
    reset_model();
    check_reset_outputs("async_rst");
    dm_req = 1'b1;
    @(posedge clk); #1;
    check("rst_load_rvalid", 32'(dm_rvalid), 32'd0);
    idle();
    rst = 1'b0;

    // Conflict: data wins for three cycles, then the fetch goes through
    idle(); if_req = 1'b1; if_addr = 32'h0C; dm_req = 1'b1; dm_funct3 = 3'd2; dm_addr = 32'h4;
    repeat (3) step();
    check("stall_cnt_3", stall_cnt, 32'd3);
    dm_req = 1'b0;
    step();
    check("fetch_after_stall", if_rdata, 32'h0050_0093);

    // Randomized traffic with aliasing addresses
    for (int i = 0; i < 2000; i++) begin
      if_req    = 1'($urandom_range(0, 1));
      if_addr   = $urandom;
      dm_req    = ($urandom_range(0, 2) != 0);
      dm_we     = 1'($urandom_range(0, 1));
      dm_funct3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
      if (!dm_we && $urandom_range(0, 1) == 1) dm_funct3 = dm_funct3 | 3'b100;
      dm_addr   = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 1) == 1) dm_addr = dm_addr & ~32'd3;
      dm_wdata  = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
